// File: rtl/cj_cosim_pkg.sv
// cj_cosim_pkg: shared types, verdict codes and mailbox helper for the cosim monitor
package cj_cosim_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } commit_t;
  localparam logic [63:0] VERDICT_NONE = 64'd0;
  localparam logic [63:0] VERDICT_PC = 64'd3;
  localparam logic [63:0] VERDICT_INSN = 64'd7;
  localparam logic [63:0] VERDICT_UNDERFLOW = 64'd9;
  localparam logic [63:0] VERDICT_TIMEOUT_RSVD = 64'd5;
  localparam logic [63:0] TOHOST_ADDR_DEFAULT = 64'h0000_0000_8000_1000;
  function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] data,
                                              input logic [7:0] strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) res[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/cj_commit_fifo.sv
// cj_commit_fifo: synchronous commit_t FIFO with occupancy count and async reset
module cj_commit_fifo
  import cj_cosim_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  commit_t       din,
  output commit_t       dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  commit_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clock)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/cj_cosim_monitor.sv
// cj_cosim_monitor: lockstep DUT-vs-golden commit checker and tohost mailbox/verdict register
module cj_cosim_monitor
  import cj_cosim_pkg::*;
#(
  parameter logic [63:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_wr_valid,
  input  logic [63:0] mem_wr_addr,
  input  logic [63:0] mem_wr_data,
  input  logic [7:0]  mem_wr_strb,
  input  logic        dut_commit_valid,
  input  logic [63:0] dut_commit_pc,
  input  logic [31:0] dut_commit_insn,
  input  logic        ref_commit_valid,
  output logic        ref_commit_ready,
  input  logic [63:0] ref_commit_pc,
  input  logic [31:0] ref_commit_insn,
  output logic [63:0] tohost,
  output logic        mismatch
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  commit_t head;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, frozen, push, pop, hit;
  logic [63:0] verdict;
  // bit0 of tohost ends the round; everything holds until reset
  assign frozen = tohost[0];
  assign push = ref_commit_valid && !fifo_full && !frozen;
  assign pop = dut_commit_valid && !frozen;
  assign ref_commit_ready = fifo_count != CW'(FIFO_DEPTH);
  assign hit = mem_wr_valid && ((mem_wr_addr ^ TOHOST_ADDR) & ~64'h7) == 64'd0;
  cj_commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({ref_commit_pc, ref_commit_insn}),
    .dout(head),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_comb
    verdict = !dut_commit_valid ? VERDICT_NONE :
              fifo_empty ? VERDICT_UNDERFLOW :
              head.pc != dut_commit_pc ? VERDICT_PC :
              head.insn != dut_commit_insn ? VERDICT_INSN : VERDICT_NONE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tohost <= '0;
      mismatch <= 1'b0;
    end else if (!frozen) begin
      if (verdict != VERDICT_NONE) begin
        tohost <= verdict;
        mismatch <= 1'b1;
      end else if (hit) tohost <= merge_bytes(tohost, mem_wr_data, mem_wr_strb);
    end
endmodule

// File: tb/tb_cj_cosim_monitor.sv
// tb_cj_cosim_monitor: directed and randomized checks against a queue-based reference model
module tb_cj_cosim_monitor;
  import cj_cosim_pkg::*;
  localparam logic [63:0] TA = 64'h0000_0000_8000_1000;
  logic clock = 0, reset;
  logic mem_wr_valid, dut_commit_valid, ref_commit_valid, ref_commit_ready, mismatch;
  logic [63:0] mem_wr_addr, mem_wr_data, dut_commit_pc, ref_commit_pc, tohost;
  logic [7:0] mem_wr_strb;
  logic [31:0] dut_commit_insn, ref_commit_insn;
  int checks = 0, errors = 0;
  commit_t q[$];
  logic [63:0] m_tohost;
  logic m_mis;

  cj_cosim_monitor dut (
    .clock(clock), .reset(reset),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb),
    .dut_commit_valid(dut_commit_valid), .dut_commit_pc(dut_commit_pc),
    .dut_commit_insn(dut_commit_insn),
    .ref_commit_valid(ref_commit_valid), .ref_commit_ready(ref_commit_ready),
    .ref_commit_pc(ref_commit_pc), .ref_commit_insn(ref_commit_insn),
    .tohost(tohost), .mismatch(mismatch)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tohost"}, tohost, m_tohost);
    chk({tag, ".mismatch"}, {63'd0, mismatch}, {63'd0, m_mis});
    chk({tag, ".ready"}, {63'd0, ref_commit_ready}, {63'd0, q.size() < 8});
  endtask

  task automatic clear_inputs();
    mem_wr_valid = 0; mem_wr_addr = 0; mem_wr_data = 0; mem_wr_strb = 0;
    dut_commit_valid = 0; dut_commit_pc = 0; dut_commit_insn = 0;
    ref_commit_valid = 0; ref_commit_pc = 0; ref_commit_insn = 0;
  endtask

  // Reference: golden queue, verdict priority, byte-lane mailbox, freeze on bit0
  task automatic model_update();
    int n = q.size();
    logic [63:0] v = 0;
    if (m_tohost[0]) return;
    if (dut_commit_valid) begin
      if (n == 0) v = 9;
      else begin
        if (q[0].pc != dut_commit_pc) v = 3;
        else if (q[0].insn != dut_commit_insn) v = 7;
        void'(q.pop_front());
      end
    end
    if (ref_commit_valid && n < 8) q.push_back('{ref_commit_pc, ref_commit_insn});
    if (v != 0) begin
      m_tohost = v;
      m_mis = 1;
    end else if (mem_wr_valid && (mem_wr_addr / 8) == (TA / 8))
      for (int i = 0; i < 8; i++) if (mem_wr_strb[i]) m_tohost[8*i +: 8] = mem_wr_data[8*i +: 8];
  endtask

  task automatic tick(input string tag);
    model_update();
    @(posedge clock);
    #1;
    check_all(tag);
    clear_inputs();
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    #2;
    q.delete();
    m_tohost = 0;
    m_mis = 0;
    check_all(tag);
    reset = 0;
  endtask

  task automatic set_push(input logic [63:0] pc, input logic [31:0] insn);
    ref_commit_valid = 1; ref_commit_pc = pc; ref_commit_insn = insn;
  endtask

  task automatic set_commit(input logic [63:0] pc, input logic [31:0] insn);
    dut_commit_valid = 1; dut_commit_pc = pc; dut_commit_insn = insn;
  endtask

  task automatic set_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    mem_wr_valid = 1; mem_wr_addr = a; mem_wr_data = d; mem_wr_strb = s;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    q.delete();
    m_tohost = 0;
    m_mis = 0;
    #3;
    check_all("reset");
    reset = 0;
    for (int i = 0; i < 4; i++) begin set_push(64'h8000_0000 + 4 * i, 32'h13); tick("match_push"); end
    for (int i = 0; i < 4; i++) begin set_commit(64'h8000_0000 + 4 * i, 32'h13); tick("match_commit"); end
    chk("match_empty", 64'(q.size()), 64'd0);
    set_write(TA, 64'hAB00, 8'h02); tick("mbox_byte1");
    set_write(TA + 8, 64'h1, 8'hFF); tick("mbox_other_addr");
    set_write(TA + 4, 64'h0000_0055_0000_0000, 8'h10); tick("mbox_unaligned");
    set_write(TA, 64'h1, 8'hFF); tick("mbox_end");
    set_commit(64'h1234, 32'h0); tick("frozen_commit");
    set_write(TA, 64'h6, 8'hFF); set_push(64'h4, 32'h4); tick("frozen_write");
    do_reset("reset2");
    for (int i = 0; i < 8; i++) begin set_push({32'd0, $urandom}, $urandom); tick("bp_fill"); end
    set_push(64'hDEAD, 32'hBEEF); tick("bp_extra");
    set_commit(q[0].pc, q[0].insn); tick("bp_pop");
    set_commit(q[0].pc, q[0].insn); set_push(64'h9000, 32'h93); tick("bp_pushpop");
    chk("bp_count", 64'(q.size()), 64'd7);
    while (q.size() > 0) begin set_commit(q[0].pc, q[0].insn); tick("bp_drain"); end
    for (int i = 0; i < 8; i++) begin set_push(64'h100 + i, 32'h13); tick("full_fill"); end
    set_write(TA, 64'h1, 8'h01); tick("full_freeze");
    do_reset("reset_full");
    set_push(64'h8000_0004, 32'h13); tick("pc_push");
    set_push(64'h8000_0008, 32'h13); tick("pc_push2");
    set_commit(64'h8000_0008, 32'h13); tick("pc_diverge");
    set_write(TA, 64'h1, 8'hFF); tick("pc_hold_write");
    set_commit(64'h8000_0008, 32'h13); tick("pc_hold_commit");
    do_reset("reset_mid");
    for (int i = 0; i < 4; i++) begin set_push(64'h8000_0000 + 4 * i, 32'h13); tick("post_push"); end
    for (int i = 0; i < 4; i++) begin set_commit(64'h8000_0000 + 4 * i, 32'h13); tick("post_commit"); end
    set_push(64'h8000_0000, 32'h13); set_commit(64'h8000_0000, 32'h13); tick("underflow");
    do_reset("reset_uf");
    set_push(64'h8000_0010, 32'h13); tick("insn_push");
    set_commit(64'h8000_0010, 32'h33); tick("insn_diff");
    do_reset("reset_insn");
    set_push(64'h40, 32'h13); tick("race_push");
    set_commit(64'h44, 32'h13); set_write(TA, 64'hAB00, 8'hFF); tick("race_verdict_wins");
    do_reset("reset_race");
    for (int c = 0; c < 1500; c++) begin
      if (m_tohost[0] && $urandom_range(3) == 0) begin
        do_reset("rnd_reset");
        continue;
      end
      if ($urandom_range(1) == 1) set_push({32'd0, $urandom}, $urandom);
      if (q.size() > 0 && $urandom_range(9) < 5) begin
        set_commit(q[0].pc, q[0].insn);
        case ($urandom_range(39))
          0: dut_commit_pc = dut_commit_pc ^ 64'h4;
          1: dut_commit_insn = dut_commit_insn ^ 32'h100;
          default: ;
        endcase
      end else if (q.size() == 0 && $urandom_range(19) == 0) set_commit({32'd0, $urandom}, $urandom);
      if ($urandom_range(4) == 0)
        set_write(TA + 64'($urandom_range(2)) * 8 + 64'($urandom_range(7)),
                  {$urandom, $urandom} & ($urandom_range(29) == 0 ? ~64'h0 : ~64'h1), 8'($urandom));
      tick("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cj_cosim_monitor.md
Name: cj_cosim_monitor

Overview:
- Co-simulation checker and tohost generator for the fuzzing testbench. It sits beside the SoC harness.
- It compares the DUT commit stream against a golden reference commit stream, and captures program writes to the tohost mailbox.
- It drives the 64-bit tohost word. The bench treats tohost bit0 = 1 as end-of-round.

Parameters:
- TOHOST_ADDR, 64'h0000_0000_8000_1000, byte address of the tohost mailbox (8-byte aligned).
- FIFO_DEPTH, 8, entries in the reference-commit buffer (power of two, at least 2).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_wr_valid  in  1  memory-bus write beat.
- mem_wr_addr  in  64  write byte address.
- mem_wr_data  in  64  write data.
- mem_wr_strb  in  8  byte enables.
- dut_commit_valid  in  1  DUT retired one instruction this cycle.
- dut_commit_pc  in  64  retired PC.
- dut_commit_insn  in  32  retired instruction bits.
- ref_commit_valid  in  1  golden commit offered.
- ref_commit_ready  out  1  buffer can accept; equals !full.
- ref_commit_pc  in  64  golden PC.
- ref_commit_insn  in  32  golden instruction bits.
- tohost  out  64  mailbox / verdict word.
- mismatch  out  1  sticky divergence flag.

Behaviour:
- Reset (async assert, sync deassert by the next clock edge):
  - tohost = 0, mismatch = 0.
  - FIFO empty; ref_commit_ready = 1.
  - Re-asserting reset mid-round clears all state immediately.
- Golden buffer:
  - Push when ref_commit_valid && ref_commit_ready.
  - Pop when dut_commit_valid.
  - No bypass: an entry pushed in cycle N is visible to compares from cycle N+1.
  - Simultaneous push and pop is legal at any occupancy below full.
  - Pointers wrap modulo FIFO_DEPTH.
- Compare, when dut_commit_valid and the FIFO is non-empty: head.pc vs dut_commit_pc, then head.insn vs dut_commit_insn.
- Verdict codes, highest priority first:
  - FIFO empty on commit (underflow): tohost <= 9.
  - PC differs: tohost <= 3.
  - Insn differs: tohost <= 7.
  - Code 5 is reserved for the bench timeout and is never produced.
- On any verdict, mismatch <= 1 on the same edge.
- Mailbox write:
  - Condition: mem_wr_valid && mem_wr_addr[63:3] == TOHOST_ADDR[63:3].
  - Each enabled byte lane replaces the corresponding tohost byte.
  - Disabled lanes keep their old value.
  - The update is registered and visible one cycle after the beat.
- Freeze: once tohost[0] = 1, tohost, mismatch and FIFO contents hold until reset.
  - Further writes, commits and pushes are ignored.
  - ref_commit_ready stays at !full.
- Same-cycle verdict and mailbox write: the verdict wins; the write is dropped.
- A mailbox write with bit0 = 0 (e.g. syscall proxy value) updates tohost without ending the round.
- Registered outputs only; there is no combinational path from inputs to tohost or mismatch.
  - ref_commit_ready depends only on the FIFO count.

Decomposition:
- Package cj_cosim_pkg holds:
  - commit_t struct {pc[63:0], insn[31:0]}.
  - Verdict constants: VERDICT_PC = 3, VERDICT_INSN = 7, VERDICT_UNDERFLOW = 9, VERDICT_TIMEOUT_RSVD = 5.
  - Default TOHOST_ADDR.
- One sub-module: cj_commit_fifo, a parameterised synchronous FIFO of commit_t with count, full and empty outputs, and async reset.
- Compare logic and mailbox register live in the top module.

Test Plan:
- Matching stream: push 4 golden commits (pc 0x80000000 + 4i, insn 0x00000013), then 4 identical DUT commits. Expect tohost = 0, mismatch = 0, FIFO empty.
- PC divergence: golden pc 0x80000004, DUT pc 0x80000008, same insn. Next cycle tohost = 3, mismatch = 1; later commits and writes leave tohost = 3.
- Underflow: DUT commit while the FIFO is empty, including a same-cycle push. Expect tohost = 9.
- Mailbox:
  - Write 0x1 with strb 0xFF to TOHOST_ADDR: tohost = 1 one cycle later.
  - Write 0xAB00 with strb 0x02 beforehand: only byte1 changes, bit0 stays 0, round continues.
  - Write to TOHOST_ADDR+8: ignored.
- Backpressure: fill 8 entries. Expect ref_commit_ready = 0; extra valid is not accepted. Simultaneous pop and push at 7 entries holds the count.
- Reset mid-round: after tohost = 3, assert reset asynchronously between edges. Expect tohost = 0, mismatch = 0, ready = 1 immediately; a matching stream after deassert passes.
